// File: rtl/lvds_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lvds_ctrl_pkg
//
// Shared definitions for the LVDS frame sequencer:
//   - pattern_e    : test-pattern encoding carried on pattern_sel
//   - COL_*        : 24-bit {r,g,b} colour constants used by the bar pattern
//   - bar_color()  : bar index (0 = leftmost) to colour lookup
//
// Optional build macro used by the sequencer: LVDS_PATTERN_SCROLL_EN
// (frame-counter driven scrolling of the gradient and checkerboard).
// ---------------------------------------------------------------------------
package lvds_ctrl_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    // Classic descending-luminance bar order, left to right.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] col;
        case (idx)
            3'd0:    col = COL_WHITE;
            3'd1:    col = COL_YELLOW;
            3'd2:    col = COL_CYAN;
            3'd3:    col = COL_GREEN;
            3'd4:    col = COL_MAGENTA;
            3'd5:    col = COL_RED;
            3'd6:    col = COL_BLUE;
            default: col = COL_BLACK;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/lvds_timing_gen.sv
// ---------------------------------------------------------------------------
// lvds_timing_gen
//
// Raster counters and sync decode. Region order on each axis is
// active, front porch, sync, back porch. All decodes are combinational
// from the current counter state; the parent registers them.
//
// Ports:
//   clk_i      pixel clock
//   reset_i    asynchronous active-high reset (counters to 0)
//   h_cnt_o    current pixel position in the line
//   v_tile_o   bit 5 of the line counter (checkerboard row phase)
//   hsync_o    high during horizontal sync
//   vsync_o    high during vertical sync lines
//   de_o       high inside the active picture area
//   sof_o      counters at (0,0)
//   eof_o      counters at (H_TOTAL-1, V_TOTAL-1), the frame boundary
// ---------------------------------------------------------------------------
module lvds_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter int unsigned HW       = 11,
    parameter int unsigned VW       = 10
) (
    input  logic          clk_i,
    input  logic          reset_i,
    output logic [HW-1:0] h_cnt_o,
    output logic          v_tile_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o,
    output logic          sof_o,
    output logic          eof_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_ONE  = HW'(1);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ONE  = VW'(1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_last ? '0 : h_cnt_q + H_ONE;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + V_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o  = h_cnt_q;
    assign v_tile_o = v_cnt_q[5];
    assign hsync_o  = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
    assign vsync_o  = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
    assign de_o     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign sof_o    = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign eof_o    = h_last && v_last;

endmodule

// File: rtl/lvds_frame_sequencer.sv
// ---------------------------------------------------------------------------
// lvds_frame_sequencer
//
// Video timing generator and test-pattern scheduler feeding the LVDS
// serializer's 8-bit r/g/b inputs. Pattern requests are captured on a load
// strobe and only switched in at the frame boundary, so no frame is torn.
// All outputs are registered, one clock after the counter state they show.
//
// Ports:
//   clk_in           pixel clock
//   reset            asynchronous active-high reset
//   solid_rgb        asynchronous switch levels {r,g,b} for the solid pattern
//   pattern_sel      requested pattern (0 solid, 1 bars, 2 gradient, 3 checker)
//   pattern_load     one-cycle strobe capturing pattern_sel
//   pattern_pending  a captured request is waiting for the frame boundary
//   red/green/blue   pixel data
//   hsync/vsync/de   active-high sync and data enable
//   frame_start      one-cycle pulse with output pixel (0,0)
//
// Build option: LVDS_PATTERN_SCROLL_EN adds an 8-bit frame counter that
// scrolls the gradient and checkerboard one pixel per frame.
// ---------------------------------------------------------------------------
module lvds_frame_sequencer
    import lvds_ctrl_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [2:0] solid_rgb,
    input  logic [1:0] pattern_sel,
    input  logic       pattern_load,
    output logic       pattern_pending,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // The gradient reads h_cnt[7:0] and the checkerboard reads v_cnt[5],
    // so the counters are never narrower than those bits.
    localparam int unsigned HW = ($clog2(H_TOTAL) < 8) ? 8 : $clog2(H_TOTAL);
    localparam int unsigned VW = ($clog2(V_TOTAL) < 6) ? 6 : $clog2(V_TOTAL);
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    // ---------------- timing ----------------
    logic [HW-1:0] h_cnt;
    logic          v_tile;
    logic          tg_hsync;
    logic          tg_vsync;
    logic          tg_de;
    logic          tg_sof;
    logic          tg_eof;

    lvds_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk_i    (clk_in),
        .reset_i  (reset),
        .h_cnt_o  (h_cnt),
        .v_tile_o (v_tile),
        .hsync_o  (tg_hsync),
        .vsync_o  (tg_vsync),
        .de_o     (tg_de),
        .sof_o    (tg_sof),
        .eof_o    (tg_eof)
    );

    // ---------------- switch synchronizer ----------------
    logic [2:0] solid_meta_q;
    logic [2:0] solid_sync_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            solid_meta_q <= '0;
            solid_sync_q <= '0;
        end else begin
            solid_meta_q <= solid_rgb;
            solid_sync_q <= solid_meta_q;
        end
    end

    // ---------------- pattern handshake ----------------
    // A request is parked in pend_pat_q until the boundary cycle. A load
    // arriving on the boundary cycle itself bypasses the parking register
    // and never raises pending.
    pattern_e active_q, active_d;
    pattern_e pend_pat_q, pend_pat_d;
    logic     pending_q, pending_d;

    always_comb begin
        active_d   = active_q;
        pend_pat_d = pend_pat_q;
        pending_d  = pending_q;
        if (tg_eof) begin
            if (pattern_load) begin
                active_d = pattern_e'(pattern_sel);
            end else if (pending_q) begin
                active_d = pend_pat_q;
            end
            pending_d = 1'b0;
        end else if (pattern_load) begin
            pend_pat_d = pattern_e'(pattern_sel);
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            active_q   <= PAT_SOLID;
            pend_pat_q <= PAT_SOLID;
            pending_q  <= 1'b0;
        end else begin
            active_q   <= active_d;
            pend_pat_q <= pend_pat_d;
            pending_q  <= pending_d;
        end
    end

    // ---------------- scroll offset ----------------
    // grad_val[5] equals (h_cnt + frame_cnt)[5] because the carry into bit 5
    // only depends on the low bits, so the checkerboard reuses it.
    logic [7:0] grad_val;

`ifdef LVDS_PATTERN_SCROLL_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (tg_eof) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign grad_val = h_cnt[7:0] + frame_cnt_q;
`else
    assign grad_val = h_cnt[7:0];
`endif

    // ---------------- pixel mux ----------------
    logic [2:0]  bar_idx;
    logic [23:0] pix_d;

    always_comb begin
        bar_idx = 3'd0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (h_cnt >= HW'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
    end

    always_comb begin
        pix_d = COL_BLACK;
        if (tg_de) begin
            case (active_q)
                PAT_SOLID: pix_d = {{8{solid_sync_q[2]}},
                                    {8{solid_sync_q[1]}},
                                    {8{solid_sync_q[0]}}};
                PAT_BARS:  pix_d = bar_color(bar_idx);
                PAT_GRAD:  pix_d = {grad_val, grad_val, grad_val};
                PAT_CHECK: pix_d = (grad_val[5] ^ v_tile) ? COL_WHITE : COL_BLACK;
                default:   pix_d = COL_BLACK;
            endcase
        end
    end

    // ---------------- output registers ----------------
    logic [23:0] pix_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        de_q;
    logic        frame_start_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pix_q         <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_q         <= pix_d;
            hsync_q       <= tg_hsync;
            vsync_q       <= tg_vsync;
            de_q          <= tg_de;
            frame_start_q <= tg_sof;
        end
    end

    assign red             = pix_q[23:16];
    assign green           = pix_q[15:8];
    assign blue            = pix_q[7:0];
    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign de              = de_q;
    assign frame_start     = frame_start_q;
    assign pattern_pending = pending_q;

endmodule

// File: tb/tb_lvds_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lvds_frame_sequencer
//
// Directed bench on a tiny raster (H_TOTAL=24, V_TOTAL=8, 192 clocks per
// frame). n is the raster index of the pixel currently on the outputs,
// sampled on the falling edge; inputs are driven on the falling edge too.
// ---------------------------------------------------------------------------
module tb_lvds_frame_sequencer;

    localparam int HT = 24;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic [2:0] solid_rgb;
    logic [1:0] pattern_sel;
    logic       pattern_load;
    logic       pattern_pending;
    logic [7:0] red, green, blue;
    logic       hsync, vsync, de, frame_start;

    always #5 clk_in = ~clk_in;

    lvds_frame_sequencer #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4),  .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .solid_rgb       (solid_rgb),
        .pattern_sel     (pattern_sel),
        .pattern_load    (pattern_load),
        .pattern_pending (pattern_pending),
        .red             (red),
        .green           (green),
        .blue            (blue),
        .hsync           (hsync),
        .vsync           (vsync),
        .de              (de),
        .frame_start     (frame_start)
    );

    int         total = 0;
    int         bad   = 0;
    int         n;
    int         cur_pat;
    logic       exp_pend;
    logic [2:0] sol_old, sol_new;
    int         sol_switch_n;
    int         fs_count;
    int         de_count;
`ifdef LVDS_PATTERN_SCROLL_EN
    localparam int SCROLL = 1;
`else
    localparam int SCROLL = 0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    function automatic logic [23:0] sol24(input logic [2:0] s);
        return {{8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [23:0] bar_rgb(input int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic check_pixel();
        int          h = n % HT;
        int          v = (n / HT) % VT;
        int          f = n / FT;
        int          hs = (h + f * SCROLL) % 256;
        logic        act = (h < 16) && (v < 4);
        logic [23:0] exp_pix = 24'h0;
        if (act) begin
            case (cur_pat)
                0: exp_pix = (n < 2) ? 24'h0 : sol24((n < sol_switch_n) ? sol_old : sol_new);
                1: exp_pix = bar_rgb(h / 2);
                2: exp_pix = {3{8'(hs)}};
                default: exp_pix = ((((hs >> 5) ^ (v >> 5)) & 1) == 1) ? 24'hFFFFFF : 24'h0;
            endcase
        end
        check("de", 32'(de), 32'(act));
        check("hsync", 32'(hsync), 32'((h >= 18) && (h <= 20)));
        check("vsync", 32'(vsync), 32'((v >= 5) && (v <= 6)));
        check("frame_start", 32'(frame_start), 32'((h == 0) && (v == 0)));
        check("rgb", 32'({red, green, blue}), 32'(exp_pix));
        check("pending", 32'(pattern_pending), 32'(exp_pend));
    endtask

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
        n++;
        check_pixel();
        if (frame_start) fs_count++;
        if (de && (n < FT)) de_count++;
    endtask

    task automatic run_to(input int m);
        while (n < m) tick();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rgb"}, 32'({red, green, blue}), 32'h0);
        check({tag, "_sync"}, 32'({hsync, vsync}), 32'h0);
        check({tag, "_de"}, 32'(de), 32'h0);
        check({tag, "_fs"}, 32'(frame_start), 32'h0);
        check({tag, "_pend"}, 32'(pattern_pending), 32'h0);
    endtask

    task automatic load(input logic [1:0] sel);
        pattern_sel  = sel;
        pattern_load = 1'b1;
        tick();
        pattern_load = 1'b0;
        pattern_sel  = 2'd0;
    endtask

    initial begin
        solid_rgb    = 3'b101;
        pattern_sel  = 2'd0;
        pattern_load = 1'b0;
        sol_old      = 3'b101;
        sol_new      = 3'b101;
        sol_switch_n = 1 << 30;
        cur_pat      = 0;
        exp_pend     = 1'b0;
        fs_count     = 0;
        de_count     = 0;
        n            = -1;

        repeat (3) @(negedge clk_in);
        check_idle("rst");
        reset = 1'b0;

        // Frames 0-1: solid 101; bars request mid frame 1.
        run_to(FT - 1);
        check("de_per_frame", 32'(de_count), 32'd64);
        run_to(250);
        exp_pend = 1'b1;
        load(2'd1);
        run_to(2 * FT - 2);
        exp_pend = 1'b0;
        tick();
        check("fs_count", 32'(fs_count), 32'd2);
        cur_pat = 1;

        // Frame 2 bars; two loads in frame 3, last (checker) wins.
        run_to(3 * FT + 24);
        exp_pend = 1'b1;
        load(2'd2);
        run_to(3 * FT + 74);
        load(2'd3);
        run_to(4 * FT - 2);
        exp_pend = 1'b0;
        tick();
        cur_pat = 3;

        // Load exactly on the boundary cycle: no pending, gradient next frame.
        run_to(5 * FT - 2);
        load(2'd2);
        cur_pat = 2;
        run_to(5 * FT);
        check("grad_px0_f5", 32'(red), 32'(5 * SCROLL));

        // Pending request then reset mid-frame.
        run_to(6 * FT + 48);
        exp_pend = 1'b1;
        load(2'd1);
        run_to(6 * FT + 98);
        reset = 1'b1;
        #1;
        check_idle("rst_mid");
        repeat (2) @(negedge clk_in);
        check_idle("rst_hold");
        n        = -1;
        exp_pend = 1'b0;
        cur_pat  = 0;
        reset    = 1'b0;

        // Epoch 2: solid again, switch change through the synchronizer.
        run_to(50);
        solid_rgb    = 3'b010;
        sol_new      = 3'b010;
        sol_switch_n = 53;
        run_to(FT - 2);
        load(2'd2);
        cur_pat = 2;
        run_to(FT);
        check("grad_px0_a", 32'(red), 32'(1 * SCROLL));
        run_to(2 * FT);
        check("grad_px0_b", 32'(red), 32'(2 * SCROLL));
        run_to(3 * FT);
        check("grad_px0_c", 32'(red), 32'(3 * SCROLL));
        run_to(3 * FT + 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
